// File: rtl/mcs4_timing_gen.sv
// MCS-4 style timing generator: divided two-phase clocks, one-hot phase ring,
// data-pad sequencing, opcode / I/O-read capture and a stop / single-step mode.
//
// state | meaning
// RUN   | normal execution, captures and pad drive enabled
// STOP  | processor halted, pads released, captures frozen
// STEP  | one granted machine cycle out of STOP
module mcs4_timing_gen #(
  parameter int DIV    = 2,
  parameter int NPHASE = 8,
  parameter int DATA_W = 4
) (
  input  logic              sysclk,
  input  logic              poc_n,
  input  logic              poc_pad,
  input  logic              stop_req,
  input  logic              step,
  input  logic              ior,
  input  logic [DATA_W-1:0] core_data,
  input  logic [DATA_W-1:0] data_pad_i,
  output logic [DATA_W-1:0] data_pad_o,
  output logic              data_pad_oe,
  output logic              clk1,
  output logic              clk2,
  output logic [NPHASE-1:0] phase,
  output logic              sync_pad,
  output logic              cycle_end,
  output logic              poc,
  output logic              stopped,
  output logic [DATA_W-1:0] opr,
  output logic [DATA_W-1:0] opa,
  output logic [DATA_W-1:0] x2_data
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  typedef enum logic [1:0] {RUN, STOP, STEP} state_t;

  state_t      state, state_nx;
  logic [DW-1:0] div;
  logic [1:0]  sub;
  logic        step_pend;
  logic        div_last, sub_last, strobe, capture_en;

  assign div_last   = (div == DIV_LAST);
  assign sub_last   = div_last && (sub == 2'd3);
  assign strobe     = div_last && (sub == 2'd2);
  assign capture_en = strobe && !stopped && !poc;
  assign sync_pad   = phase[NPHASE-1];
  assign cycle_end  = phase[NPHASE-1] && sub_last;

  always_ff @(posedge sysclk or negedge poc_n) begin
    if (!poc_n) begin
      div   <= '0;
      sub   <= 2'd0;
      phase <= {{(NPHASE-1){1'b0}}, 1'b1};
    end else begin
      div <= div_last ? '0 : div + DW'(1);
      if (div_last) sub <= sub + 2'd1;
      if (sub_last) phase <= {phase[NPHASE-2:0], phase[NPHASE-1]};
    end
  end

  // POC stays asserted until the ring is back at A1 with the pad released.
  always_ff @(posedge sysclk or negedge poc_n) begin
    if (!poc_n)       poc <= 1'b1;
    else if (poc_pad) poc <= 1'b1;
    else if (phase[0]) poc <= 1'b0;
  end

  always_ff @(posedge sysclk or negedge poc_n) begin
    if (!poc_n)                  step_pend <= 1'b0;
    else if (poc || cycle_end)   step_pend <= 1'b0;
    else if (step && stopped)    step_pend <= 1'b1;
  end

  always_ff @(posedge sysclk or negedge poc_n) begin
    if (!poc_n) begin
      opr     <= '0;
      opa     <= '0;
      x2_data <= '0;
    end else if (capture_en) begin
      if (phase[3])        opr     <= data_pad_i;
      if (phase[4])        opa     <= data_pad_i;
      if (phase[6] && ior) x2_data <= data_pad_i;
    end
  end

  always_ff @(posedge sysclk or negedge poc_n) begin
    if (!poc_n) state <= RUN;
    else        state <= state_nx;
  end

  // A step arriving on the boundary itself is granted at that boundary.
  always_comb begin
    state_nx = state;
    if (poc) begin
      state_nx = RUN;
    end else if (cycle_end) begin
      case (state)
        RUN:     state_nx = stop_req ? STOP : RUN;
        STOP: begin
          if (!stop_req)               state_nx = RUN;
          else if (step_pend || step)  state_nx = STEP;
        end
        STEP:    state_nx = stop_req ? STOP : RUN;
        default: state_nx = RUN;
      endcase
    end
  end

  always_comb begin
    stopped     = (state == STOP) && !poc;
    clk1        = (sub == 2'd0);
    clk2        = (sub == 2'd2);
    data_pad_oe = 1'b0;
    data_pad_o  = '0;
    if (poc) begin
      data_pad_oe = 1'b1;
    end else if (stopped) begin
      data_pad_oe = 1'b0;
    end else if ((|phase[2:0]) || (phase[6] && !ior)) begin
      data_pad_oe = 1'b1;
      data_pad_o  = core_data;
    end
  end

endmodule

// File: tb/tb_mcs4_timing_gen.sv
// Self-checking bench for mcs4_timing_gen: timing scoreboard, per-phase pad
// vector table, and hand sequences for POC, stop / single-step and async reset.
module tb_mcs4_timing_gen;

  logic       sysclk, poc_n, poc_pad, stop_req, step, ior;
  logic [3:0] core_data, data_pad_i;
  logic [3:0] data_pad_o, opr, opa, x2_data;
  logic       data_pad_oe, clk1, clk2, sync_pad, cycle_end, poc, stopped;
  logic [7:0] phase;

  logic [3:0] data_pad_o2, opr2, opa2, x2_data2;
  logic       data_pad_oe2, clk1_2, clk2_2, sync_pad2, cycle_end2, poc2, stopped2;
  logic [9:0] phase2;

  mcs4_timing_gen #(.DIV(2), .NPHASE(8), .DATA_W(4)) u_dut (
    .sysclk(sysclk), .poc_n(poc_n), .poc_pad(poc_pad), .stop_req(stop_req),
    .step(step), .ior(ior), .core_data(core_data), .data_pad_i(data_pad_i),
    .data_pad_o(data_pad_o), .data_pad_oe(data_pad_oe), .clk1(clk1), .clk2(clk2),
    .phase(phase), .sync_pad(sync_pad), .cycle_end(cycle_end), .poc(poc),
    .stopped(stopped), .opr(opr), .opa(opa), .x2_data(x2_data));

  mcs4_timing_gen #(.DIV(1), .NPHASE(10), .DATA_W(4)) u_dut2 (
    .sysclk(sysclk), .poc_n(poc_n), .poc_pad(poc_pad), .stop_req(stop_req),
    .step(step), .ior(ior), .core_data(core_data), .data_pad_i(data_pad_i),
    .data_pad_o(data_pad_o2), .data_pad_oe(data_pad_oe2), .clk1(clk1_2), .clk2(clk2_2),
    .phase(phase2), .sync_pad(sync_pad2), .cycle_end(cycle_end2), .poc(poc2),
    .stopped(stopped2), .opr(opr2), .opa(opa2), .x2_data(x2_data2));

  typedef struct {
    logic       clk1, clk2, sync, cend, oe;
    logic [7:0] ph;
    logic [3:0] o;
    logic       clk1_2, clk2_2, sync2, cend2;
    logic [9:0] ph2;
  } exp_t;

  typedef struct {
    logic       ior;
    logic [3:0] core, pad;
    logic       oe;
    logic [3:0] o, opr, opa, x2;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[16];
  int   n_vec = 0;
  int   n_err = 0;
  int   kc = 0;

  initial begin
    sysclk = 1'b0;
    forever #5 sysclk = ~sysclk;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h (t=%0t kc=%0d)", name, act, exp, $time, kc);
    end
  endtask

  task automatic adv();
    @(negedge sysclk);
    #1;
    kc++;
  endtask

  task automatic goto(input int tgt);
    for (int i = 0; i < 64; i++) begin
      if (kc % 64 == tgt) break;
      adv();
    end
  endtask

  // Reference timing derived arithmetically from the sysclk count since release.
  function automatic exp_t model(input int k, input logic ior_v,
                                 input logic [3:0] core_v, input logic poc_v);
    exp_t e;
    int   s1, p1, k2;
    s1 = (k / 2) % 4;
    p1 = (k / 8) % 8;
    k2 = k % 40;
    e.clk1   = (s1 == 0);
    e.clk2   = (s1 == 2);
    e.ph     = 8'b1 << p1;
    e.sync   = (p1 == 7);
    e.cend   = (p1 == 7) && (k % 8 == 7);
    e.ph2    = 10'b1 << (k2 / 4);
    e.clk1_2 = (k2 % 4 == 0);
    e.clk2_2 = (k2 % 4 == 2);
    e.sync2  = (k2 >= 36);
    e.cend2  = (k2 == 39);
    if (poc_v) begin
      e.oe = 1'b1; e.o = 4'h0;
    end else if (p1 <= 2 || (p1 == 6 && !ior_v)) begin
      e.oe = 1'b1; e.o = core_v;
    end else begin
      e.oe = 1'b0; e.o = 4'h0;
    end
    return e;
  endfunction

  task automatic cmp_sb(input bit with2);
    exp_t e;
    e = sb.pop_front();
    chk("clk1", clk1, e.clk1);
    chk("clk2", clk2, e.clk2);
    chk("clk_overlap", clk1 & clk2, 0);
    chk("phase", phase, e.ph);
    chk("sync_pad", sync_pad, e.sync);
    chk("cycle_end", cycle_end, e.cend);
    chk("pad_oe", data_pad_oe, e.oe);
    chk("pad_o", data_pad_o, e.o);
    if (with2) begin
      chk("d2_phase", phase2, e.ph2);
      chk("d2_clk1", clk1_2, e.clk1_2);
      chk("d2_clk2", clk2_2, e.clk2_2);
      chk("d2_sync", sync_pad2, e.sync2);
      chk("d2_cycle_end", cycle_end2, e.cend2);
    end
  endtask

  initial begin
    exp_t e;
    //              ior  core   pad    oe    o      opr    opa    x2
    tbl[0]  = '{1'b1, 4'h1, 4'h0, 1'b1, 4'h1, 4'hD, 4'h5, 4'h0};
    tbl[1]  = '{1'b1, 4'h2, 4'h0, 1'b1, 4'h2, 4'hD, 4'h5, 4'h0};
    tbl[2]  = '{1'b1, 4'h4, 4'h0, 1'b1, 4'h4, 4'hD, 4'h5, 4'h0};
    tbl[3]  = '{1'b1, 4'h7, 4'h5, 1'b0, 4'h0, 4'h5, 4'h5, 4'h0};
    tbl[4]  = '{1'b1, 4'h7, 4'hA, 1'b0, 4'h0, 4'h5, 4'hA, 4'h0};
    tbl[5]  = '{1'b1, 4'hF, 4'h0, 1'b0, 4'h0, 4'h5, 4'hA, 4'h0};
    tbl[6]  = '{1'b1, 4'hC, 4'h3, 1'b0, 4'h0, 4'h5, 4'hA, 4'h3};
    tbl[7]  = '{1'b1, 4'hF, 4'h0, 1'b0, 4'h0, 4'h5, 4'hA, 4'h3};
    tbl[8]  = '{1'b0, 4'h9, 4'h0, 1'b1, 4'h9, 4'h5, 4'hA, 4'h3};
    tbl[9]  = '{1'b0, 4'h6, 4'h0, 1'b1, 4'h6, 4'h5, 4'hA, 4'h3};
    tbl[10] = '{1'b0, 4'h3, 4'h0, 1'b1, 4'h3, 4'h5, 4'hA, 4'h3};
    tbl[11] = '{1'b0, 4'h7, 4'h6, 1'b0, 4'h0, 4'h6, 4'hA, 4'h3};
    tbl[12] = '{1'b0, 4'h7, 4'h9, 1'b0, 4'h0, 4'h6, 4'h9, 4'h3};
    tbl[13] = '{1'b0, 4'hF, 4'h0, 1'b0, 4'h0, 4'h6, 4'h9, 4'h3};
    tbl[14] = '{1'b0, 4'hC, 4'hE, 1'b1, 4'hC, 4'h6, 4'h9, 4'h3};
    tbl[15] = '{1'b0, 4'hF, 4'h0, 1'b0, 4'h0, 4'h6, 4'h9, 4'h3};

    poc_n = 1'b0; poc_pad = 1'b0; stop_req = 1'b0; step = 1'b0; ior = 1'b0;
    core_data = 4'h0; data_pad_i = 4'h0;
    repeat (2) @(negedge sysclk);
    #1;
    chk("rst_phase", phase, 8'h01);
    chk("rst_clk1", clk1, 1);
    chk("rst_clk2", clk2, 0);
    chk("rst_poc", poc, 1);
    chk("rst_stopped", stopped, 0);
    chk("rst_opr", opr, 0);
    chk("rst_opa", opa, 0);
    chk("rst_x2", x2_data, 0);
    chk("rst_oe", data_pad_oe, 1);
    chk("rst_d2_phase", phase2, 10'h001);

    // Timing pass: one default machine cycle, scoreboarded against the model.
    @(negedge sysclk);
    poc_n = 1'b1;
    kc = 0;
    #1;
    for (int k = 0; k < 64; k++) begin
      data_pad_i = 4'(k);
      core_data  = 4'(~k);
      ior        = 1'b0;
      sb.push_back(model(k, 1'b0, 4'(~k), k == 0));
      #1;
      cmp_sb(1'b1);
      if (k == 39) begin
        chk("d2_opr_idx3", opr2, 4'hE);
        chk("d2_opa_idx4", opa2, 4'h2);
      end
      if (k < 63) adv();
    end
    chk("d2_opr_c2", opr2, 4'h6);
    chk("d2_opa_c2", opa2, 4'hA);
    adv();

    // Per-phase pad vectors over two cycles (I/O read, then write).
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 8; j++) begin
        ior        = tbl[i].ior;
        core_data  = tbl[i].core;
        data_pad_i = tbl[i].pad;
        e = model(kc % 64, tbl[i].ior, tbl[i].core, 1'b0);
        e.oe = tbl[i].oe;
        e.o  = tbl[i].o;
        sb.push_back(e);
        #1;
        cmp_sb(1'b0);
        if (j == 7) begin
          chk("tbl_opr", opr, tbl[i].opr);
          chk("tbl_opa", opa, tbl[i].opa);
          chk("tbl_x2", x2_data, tbl[i].x2);
        end
        adv();
      end
    end

    // POC pulse in X1.
    ior = 1'b0; core_data = 4'hF; data_pad_i = 4'hB;
    goto(42);
    poc_pad = 1'b1;
    adv();
    poc_pad = 1'b0;
    chk("poc_set", poc, 1);
    goto(50);
    chk("poc_x2_oe", data_pad_oe, 1);
    chk("poc_x2_o", data_pad_o, 0);
    goto(63);
    chk("poc_hold_end", poc, 1);
    adv();
    chk("poc_hold_a1", poc, 1);
    adv();
    chk("poc_clear", poc, 0);
    chk("poc_clear_o", data_pad_o, 4'hF);
    data_pad_i = 4'hD;
    goto(8);
    poc_pad = 1'b1;
    adv();
    chk("poc_a2_oe", data_pad_oe, 1);
    chk("poc_a2_o", data_pad_o, 0);
    goto(63);
    chk("poc_opr_frozen", opr, 4'hB);
    chk("poc_opa_frozen", opa, 4'hB);
    poc_pad = 1'b0;
    adv();
    data_pad_i = 4'h0;
    chk("poc_still_a1", poc, 1);
    adv();
    chk("poc_released", poc, 0);
    goto(63);
    chk("post_poc_opr", opr, 0);

    // Stop / single-step.
    adv();
    goto(8);
    step = 1'b1; adv(); step = 1'b0;
    goto(16);
    stop_req = 1'b1;
    goto(63);
    chk("stop_not_yet", stopped, 0);
    chk("stop_cend", cycle_end, 1);
    adv();
    chk("stop_entered", stopped, 1);
    goto(8);
    data_pad_i = 4'h3;
    #1;
    chk("stop_oe", data_pad_oe, 0);
    goto(63);
    chk("stop_opr_frozen", opr, 0);
    adv();
    chk("run_step_ignored", stopped, 1);
    goto(16);
    step = 1'b1; adv(); step = 1'b0;
    goto(40);
    step = 1'b1; adv(); step = 1'b0;
    goto(63);
    chk("step_wait", stopped, 1);
    adv();
    chk("step_granted", stopped, 0);
    goto(24); data_pad_i = 4'h8;
    goto(32); data_pad_i = 4'h7;
    goto(40);
    chk("step_opr", opr, 4'h8);
    chk("step_opa", opa, 4'h7);
    goto(63);
    chk("step_whole_cycle", stopped, 0);
    adv();
    chk("step_back_stop", stopped, 1);
    data_pad_i = 4'h1;
    goto(63);
    chk("stop_again", stopped, 1);
    step = 1'b1; adv(); step = 1'b0;
    chk("step_on_boundary", stopped, 0);
    goto(63);
    chk("step_boundary_opr", opr, 4'h1);
    adv();
    chk("step_boundary_back", stopped, 1);
    goto(63);
    adv();
    chk("no_leftover_step", stopped, 1);
    goto(16);
    stop_req = 1'b0;
    goto(63);
    chk("release_wait", stopped, 1);
    adv();
    chk("release_run", stopped, 0);

    // Async reset in M2 while stopped.
    stop_req = 1'b1;
    goto(63);
    adv();
    chk("pre_rst_stopped", stopped, 1);
    goto(32);
    #1;
    poc_n = 1'b0;
    #1;
    chk("arst_phase", phase, 8'h01);
    chk("arst_clk1", clk1, 1);
    chk("arst_clk2", clk2, 0);
    chk("arst_poc", poc, 1);
    chk("arst_stopped", stopped, 0);
    chk("arst_opr", opr, 0);
    chk("arst_opa", opa, 0);
    chk("arst_x2", x2_data, 0);
    stop_req = 1'b0;
    @(negedge sysclk);
    poc_n = 1'b1;
    kc = 0;
    #1;
    chk("restart_phase0", phase, 8'h01);
    chk("restart_clk1", clk1, 1);
    repeat (4) adv();
    chk("restart_clk2", clk2, 1);
    chk("restart_phase_hold", phase, 8'h01);
    repeat (4) adv();
    chk("restart_phase1", phase, 8'h02);
    chk("restart_run", stopped, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mcs4_timing_gen.md
Name: mcs4_timing_gen

Overview:
- Parametrised successor to the MCS-4 timing and I/O pad block.
- Generates the two-phase clk1/clk2 internally from sysclk using a programmable divider, instead of taking them from pads.
- Drives a one-hot instruction-phase ring of configurable length and sequences the data-pad direction, opcode capture and I/O-read capture per phase.
- Adds a 4040-style stop/single-step mode. Sits between the external pads and the CPU core.

Parameters:
- DIV, 2: sysclk cycles per sub-phase (≥1).
- NPHASE, 8: instruction phases per machine cycle (≥8). Indices 0–2 are A1–A3, 3–4 are M1–M2, 5..NPHASE-1 are X phases. X2 is index 6; the last index is the final X phase.
- DATA_W, 4: data bus width.

Ports:
- sysclk  in  1  system clock
- poc_n  in  1  asynchronous active-low reset
- poc_pad  in  1  external power-on-clear request, synchronous, active-high
- stop_req  in  1  stop request, level
- step  in  1  single-step request, one-sysclk pulse
- ior  in  1  current cycle is an I/O read
- core_data  in  DATA_W  data from core to pads
- data_pad_i  in  DATA_W  pad input
- data_pad_o  out  DATA_W  pad output value
- data_pad_oe  out  1  pad output enable
- clk1  out  1  phase-1 clock
- clk2  out  1  phase-2 clock
- phase  out  NPHASE  one-hot phase ring
- sync_pad  out  1  SYNC, high during the last phase
- cycle_end  out  1  pulse on the last sysclk of a machine cycle
- poc  out  1  conditioned power-on clear
- stopped  out  1  processor in stop state
- opr  out  DATA_W  opcode high nibble, captured in M1
- opa  out  DATA_W  opcode low nibble, captured in M2
- x2_data  out  DATA_W  pad data captured in X2 of I/O read cycles

Behaviour:
- Reset (poc_n=0, asynchronous) values:
  - div counter = 0, sub = 0, phase = one-hot index 0.
  - poc = 1, stopped = 0, step_pend = 0.
  - opr = opa = x2_data = 0.
- Counters:
  - div counts 0..DIV-1. sub (2 bits) advances when div == DIV-1.
  - Ring rotates (index i → i+1, last → 0) on the sysclk where sub == 3 and div == DIV-1.
  - Machine cycle = NPHASE·4·DIV sysclk (64 at defaults).
- Clocks:
  - clk1 = (sub == 0), clk2 = (sub == 2), decoded from registers only; never both high.
  - clk1 is high immediately after reset release.
- sync_pad = phase[NPHASE-1], combinational.
- cycle_end = phase[NPHASE-1] & sub == 3 & div == DIV-1.
- Capture strobe = sub == 2 & div == DIV-1, i.e. the last sysclk of clk2.
  - Phase 3 strobe: opr ← data_pad_i.
  - Phase 4 strobe: opa ← data_pad_i.
  - Phase 6 strobe with ior = 1: x2_data ← data_pad_i.
  - None of these update while stopped = 1 or poc = 1.
- Pad drive, by priority:
  1. poc = 1: oe = 1, o = 0.
  2. stopped = 1: oe = 0.
  3. Phases 0–2: oe = 1, o = core_data.
  4. Phase 6 with ior = 0: oe = 1, o = core_data.
  5. Otherwise: oe = 0.
  - data_pad_o is 0 whenever oe = 0.
- POC:
  - Set on any sysclk with poc_pad = 1.
  - Cleared on a sysclk where phase[0] = 1 and poc_pad = 0.
  - While poc = 1: stopped and step_pend are held 0.
- Stop state machine, states RUN / STOP, evaluated only at cycle_end:
  - RUN → STOP if stop_req = 1.
  - STOP → RUN if stop_req = 0.
  - STOP with step_pend = 1 and stop_req = 1 → STOP' (stopped = 0 for exactly one cycle). step_pend is cleared. At the next cycle_end, stop_req = 1 returns to STOP.
  - step sets step_pend only while stopped = 1. step in RUN is ignored. Extra steps before the boundary coalesce into one.
  - step coincident with cycle_end while stopped: that boundary already grants the step.
- stop_req changes mid-cycle take effect only at the next cycle_end; the ring and clocks never stall.
- Asynchronous reset mid-cycle aborts everything and returns to the reset values above.

Test Plan:
- Defaults, release reset: clk1 high for sysclk 0–1, clk2 high for 4–5; phase advances every 8 sysclk; sync_pad high for sysclk 56–63; cycle_end only at sysclk 63; no cycle where clk1 & clk2.
- DIV=1, NPHASE=10: cycle = 40 sysclk; sync_pad on index 9; opr/opa capture still at indices 3/4.
- Pads drive 0x5 in M1 and 0xA in M2 → opr=0x5, opa=0xA after M2. With ior=1, pad 0x3 in X2 → x2_data=0x3 and oe=0 throughout X2. With ior=0, oe=1 in X2 and data_pad_o=core_data.
- poc_pad pulse in X1 → poc=1, oe=1 and o=0 until the first A1 sysclk with poc_pad low; opr unchanged meanwhile.
- stop_req raised mid-cycle → stopped rises at that cycle's cycle_end. A step pulse gives exactly one cycle with stopped=0 and opr/opa updated, then stopped returns. Dropping stop_req → RUN at the next boundary.
- poc_n asserted in phase 4 with stopped=1 → immediate reset values; after release, normal timing restarts from index 0.
